axis_packet_fifo: RTL

Parametrised single-clock AXI-Stream buffer for multi-word packets. It replaces the single-word, two-clock slave/master cache handshake with a DEPTH-word circular buffer that stores tdata, tstrb and tlast. The buffer runs in cut-through mode, or in store-and-forward mode where a packet is released only once its tlast word has been stored. It sits between a stream producer and the memory-write master path.

---
 rtl/axis_packet_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axis_packet_fifo.sv
// -----------------------------------------------------------------------------
// axis_packet_fifo
//
// Single-clock AXI-Stream packet buffer. Words (tdata, tstrb, tlast) go into a
// DEPTH-entry circular buffer. There are two release modes:
//   - cut-through (STORE_AND_FORWARD=0): a word is offered downstream as soon
//     as it is stored.
//   - store-and-forward (STORE_AND_FORWARD=1): a word is offered only when at
//     least one complete packet (a stored tlast word) is waiting. If the
//     buffer fills before any tlast arrives, the packet can never complete.
//     In that case a bypass drains it in cut-through fashion until its tlast
//     word is read, and the sticky oversize flag is raised.
//
// Ports:
//   axis_aclk        clock for all logic
//   axis_areset      synchronous active-high reset
//   s01_axis_*       upstream slave stream (tdata, tstrb, tvalid, tlast, tready)
//   m01_axis_*       downstream master stream (tdata, tstrb, tvalid, tlast, tready)
//   occupancy        number of words currently stored
//   pkt_count        number of stored tlast words not yet read out
//   oversize         sticky: a store-and-forward packet exceeded DEPTH words
// -----------------------------------------------------------------------------
module axis_packet_fifo #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 16,
    parameter bit STORE_AND_FORWARD = 1'b1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    oversize
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              SW         = DATA_WIDTH / 8;
    localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    // Storage array
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [SW-1:0]         strb_mem_q [DEPTH];
    logic                  last_mem_q [DEPTH];

    // Control state
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q,    occ_d;
    logic [AW:0]   pkt_q,    pkt_d;
    logic          bypass_q, bypass_d;
    logic          oversize_q, oversize_d;

    logic wr_en;
    logic rd_en;
    logic wr_last;
    logic rd_last;
    logic release_ok;

    // -------------------------------------------------------------------------
    // Handshake and output datapath. Everything here comes from registered
    // state (plus reset), so a word that is on offer cannot change or be
    // withdrawn until it is consumed.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        s01_axis_tready = !axis_areset && (occ_q != FULL_LEVEL);

        // Store-and-forward holds words back until a full packet is present,
        // unless the bypass is draining a packet that could never fit.
        release_ok      = STORE_AND_FORWARD ? ((pkt_q != '0) || bypass_q) : 1'b1;
        m01_axis_tvalid = !axis_areset && (occ_q != '0) && release_ok;

        m01_axis_tdata = '0;
        m01_axis_tstrb = '0;
        m01_axis_tlast = 1'b0;
        if (m01_axis_tvalid) begin
            m01_axis_tdata = data_mem_q[rd_ptr_q];
            m01_axis_tstrb = strb_mem_q[rd_ptr_q];
            m01_axis_tlast = last_mem_q[rd_ptr_q];
        end
    end

    assign wr_en   = s01_axis_tvalid && s01_axis_tready;
    assign rd_en   = m01_axis_tvalid && m01_axis_tready;
    assign wr_last = wr_en && s01_axis_tlast;
    assign rd_last = rd_en && m01_axis_tlast;

    assign occupancy = occ_q;
    assign pkt_count = pkt_q;
    assign oversize  = oversize_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_d      = pkt_q;
        bypass_d   = bypass_q;
        oversize_d = oversize_q;

        // Pointers wrap on their own; full/empty come from occ_q instead.
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;

        if (wr_en && !rd_en)      occ_d = occ_q + CNT_ONE;
        else if (rd_en && !wr_en) occ_d = occ_q - CNT_ONE;

        if (wr_last && !rd_last)      pkt_d = pkt_q + CNT_ONE;
        else if (rd_last && !wr_last) pkt_d = pkt_q - CNT_ONE;

        // Full with no complete packet would deadlock store-and-forward.
        // The set and clear conditions are mutually exclusive: a tlast
        // read needs pkt_q != 0.
        if (STORE_AND_FORWARD && (occ_q == FULL_LEVEL) && (pkt_q == '0)) begin
            bypass_d   = 1'b1;
            oversize_d = 1'b1;
        end
        if (rd_last) bypass_d = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_q      <= '0;
            bypass_q   <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_q      <= pkt_d;
            bypass_q   <= bypass_d;
            oversize_q <= oversize_d;
        end
    end

    // NOTE: the storage array has no reset. Stale entries are never visible:
    // the output is gated by tvalid, which depends on occupancy, and
    // occupancy is reset.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            data_mem_q[wr_ptr_q] <= s01_axis_tdata;
            strb_mem_q[wr_ptr_q] <= s01_axis_tstrb;
            last_mem_q[wr_ptr_q] <= s01_axis_tlast;
        end
    end

endmodule
